frag_issue_seq: RTL
===================

// Module: frag_issue_seq
// PURPOSE
//  Fetch-side sequencer for the CGRA ISA. Accepts 32-bit instruction words over valid/ready and decodes them
//  with the existing `decoder`. Tracks fragment start/end (op 101, nalloc, endF) and folds T/I prefixes into
//  the following main instruction (ALU 000, load 001, store 010). Emits one issue packet per main instruction.
// PARAMETERS
//  NALLOC_W  7   width of fragment instruction counter (matches decoder nalloc)
//  TA_W      6   target address width (matches decoder ta1..ta4)
// PORTS
//  clk          in   1    clock
//  rst          in   1    synchronous reset, active-high
//  instr_valid  in   1    instruction word valid
//  instr_ready  out  1    word accepted when valid&ready
//  instr        in   32   instruction word
//  iss_valid    out  1    issue packet valid
//  iss_ready    in   1    downstream accepts packet
//  iss_op       out  3    main opcode (000/001/010)
//  iss_funct    out  4    decoder funct
//  iss_imm      out  32   merged immediate
//  iss_ta       out  24   {ta4,ta3,ta2,ta1}; ta3/ta4 zero without T prefix
//  iss_tt       out  8    {tt4,tt3,tt2,tt1}
//  iss_ntgt     out  3    number of valid targets: 2, or 4 with T prefix
//  frag_start   out  1    one-cycle pulse when a fragment opens
//  frag_done    out  1    one-cycle pulse when a fragment closes
//  err          out  1    one-cycle pulse on a protocol error (cases listed below)
// BEHAVIOUR
//  Reset: state=IDLE, remaining count=0, prefix flags=0. All outputs 0; instr_ready=1 from the first cycle after reset.
//   rst dominates all other events. A held packet or partial prefix is discarded.
//  Output register: single entry. instr_ready = !iss_valid | iss_ready. This applies to every word, prefixes included.
//   The packet holds stable while iss_valid & !iss_ready. Latency from main word accept to iss_valid is 1 cycle.
//  FSM IDLE:
//   - Op 101 with endF=0 and nalloc!=0: load rem=nalloc, pulse frag_start, go to FRAG.
//   - Op 101 with nalloc==0, or any other op: drop the word, pulse err.
//  FSM FRAG:
//   - T prefix (011): latch ta3/ta4/tt3/tt4 and set tflag.
//   - I prefix (100): latch immhi[25:0] and set iflag.
//   - A second T or I prefix before a main word overwrites the first and pulses err.
//   - Main word (000/001/010): load the output register, clear both flags, rem <= rem-1.
//     If rem==1, also pulse frag_done and go to IDLE in the same cycle.
//   - Op 101 with endF=1: pulse frag_done, go to IDLE, clear flags.
//     Pulse err if rem!=0 or any prefix flag was pending.
//   - Op 101 with endF=0 (nested start): drop the word, pulse err.
//   - Ops 110/111 in either state: drop the word, pulse err. State is unchanged.
//  Immediate: iflag ? {immhi,immlo} : sign-extend immlo[5] to 32. immab is passed through to iss_funct only via decoder.
//  Events in one cycle: an output handshake and a new accept may coincide (back-to-back issue, no bubble).
//   frag_done and frag_start never pulse in the same cycle.
// CONFIGURATION
//  SEQ_PERF_CNT_EN defined: adds ports perf_issued (out, 32) and perf_stall (out, 32).
//   perf_issued counts iss_valid&iss_ready handshakes.
//   perf_stall counts cycles with iss_valid&!iss_ready.
//   Both counters are 0 on reset and wrap at 2^32.
//  SEQ_PERF_CNT_EN undefined: the ports and counters are absent. Behaviour is otherwise identical.
// STRUCTURE
//  Shared package cgra_isa_pkg holds:
//   - opcode constants OP_ALU=3'b000, OP_LD=3'b001, OP_ST=3'b010, OP_TPFX=3'b011, OP_IPFX=3'b100, OP_FRAG=3'b101
//   - FSM state typedef {IDLE, FRAG}
//   - widths NALLOC_W and TA_W
//  Instantiates the existing `decoder` unchanged.
//  One new sub-module, prefix_merge: holds the prefix flags and latches, and forms iss_imm/iss_ta/iss_tt/iss_ntgt.
// TESTING
//  1. Reset, then FRAG nalloc=2 / ALU / LD with iss_ready=1:
//     frag_start 1 cycle after accept; 2 packets; frag_done with the LD accept; state IDLE.
//  2. In FRAG, I prefix immhi=26'h2AAAAAA then ALU immlo=6'h15 -> iss_imm=32'hAAAAAA95, iss_ntgt=2.
//  3. T prefix ta3=6'h2A ta4=6'h3C tt3=2'b10 tt4=2'b11 then ST
//     -> iss_ta[23:12]=12'hF2A, iss_tt[7:4]=4'b1110, iss_ntgt=4.
//  4. iss_ready=0 for 5 cycles with a packet held:
//     instr_ready=0, packet stable; back-to-back issue resumes with no bubble when ready rises.
//  5. ALU word in IDLE, then op 111, then FRAG end with rem=3:
//     err pulses 3 times; the end word returns the FSM to IDLE.
//  6. rst asserted while a packet is held and the T flag is set:
//     next cycle iss_valid=0, flags=0, IDLE; SEQ_PERF_CNT_EN build shows perf counters=0.

Source files
------------

// File: rtl/cgra_isa_pkg.sv
// Shared CGRA ISA definitions: opcodes, field widths and fetch-sequencer states.
package cgra_isa_pkg;

  localparam int NALLOC_W = 7;
  localparam int TA_W     = 6;

  localparam logic [2:0] OP_ALU  = 3'b000;
  localparam logic [2:0] OP_LD   = 3'b001;
  localparam logic [2:0] OP_ST   = 3'b010;
  localparam logic [2:0] OP_TPFX = 3'b011;
  localparam logic [2:0] OP_IPFX = 3'b100;
  localparam logic [2:0] OP_FRAG = 3'b101;

  typedef enum logic {
    IDLE = 1'b0,
    FRAG = 1'b1
  } state_t;

endpackage

// File: rtl/frag_issue_seq_if.sv
// Instruction-in and issue-out handshake bundle for frag_issue_seq.
interface frag_issue_seq_if;

  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;

  logic        iss_valid;
  logic        iss_ready;
  logic [2:0]  iss_op;
  logic [3:0]  iss_funct;
  logic [31:0] iss_imm;
  logic [23:0] iss_ta;
  logic [7:0]  iss_tt;
  logic [2:0]  iss_ntgt;

  modport master (
    output instr_valid, instr, iss_ready,
    input  instr_ready, iss_valid, iss_op, iss_funct, iss_imm, iss_ta, iss_tt, iss_ntgt
  );

  modport slave (
    input  instr_valid, instr, iss_ready,
    output instr_ready, iss_valid, iss_op, iss_funct, iss_imm, iss_ta, iss_tt, iss_ntgt
  );

endinterface

// File: rtl/decoder.sv
// Field decoder for 32-bit CGRA words; fields overlap because each opcode has its own format.
module decoder
  import cgra_isa_pkg::*;
(
  input  logic [31:0]         instr,
  output logic [2:0]          op,
  output logic [3:0]          funct,
  output logic [5:0]          immlo,
  output logic [25:0]         immhi,
  output logic [TA_W-1:0]     ta1,
  output logic [TA_W-1:0]     ta2,
  output logic [TA_W-1:0]     ta3,
  output logic [TA_W-1:0]     ta4,
  output logic [1:0]          tt1,
  output logic [1:0]          tt2,
  output logic [1:0]          tt3,
  output logic [1:0]          tt4,
  output logic [NALLOC_W-1:0] nalloc,
  output logic                endf
);

  assign op     = instr[31:29];
  // immab rides in the top bit of funct
  assign funct  = {instr[25], instr[28:26]};
  assign immlo  = instr[23:18];
  assign ta1    = instr[17:12];
  assign ta2    = instr[11:6];
  assign tt1    = instr[5:4];
  assign tt2    = instr[3:2];
  assign immhi  = instr[25:0];
  assign ta3    = instr[28:23];
  assign ta4    = instr[22:17];
  assign tt3    = instr[16:15];
  assign tt4    = instr[14:13];
  assign nalloc = instr[28:22];
  assign endf   = instr[21];

endmodule

// File: rtl/frag_issue_seq_prefix_merge.sv
// Holds pending T/I prefix state and merges it into the next main word's immediate and targets.
module prefix_merge
  import cgra_isa_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            set_t,
  input  logic            set_i,
  input  logic            clr,
  input  logic [TA_W-1:0] ta1,
  input  logic [TA_W-1:0] ta2,
  input  logic [TA_W-1:0] ta3,
  input  logic [TA_W-1:0] ta4,
  input  logic [1:0]      tt1,
  input  logic [1:0]      tt2,
  input  logic [1:0]      tt3,
  input  logic [1:0]      tt4,
  input  logic [25:0]     immhi,
  input  logic [5:0]      immlo,
  output logic            pending,
  output logic [31:0]     imm,
  output logic [23:0]     ta,
  output logic [7:0]      tt,
  output logic [2:0]      ntgt
);

  logic            tflag, iflag;
  logic [TA_W-1:0] ta3_q, ta4_q;
  logic [1:0]      tt3_q, tt4_q;
  logic [25:0]     immhi_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tflag   <= 1'b0;
      iflag   <= 1'b0;
      ta3_q   <= '0;
      ta4_q   <= '0;
      tt3_q   <= '0;
      tt4_q   <= '0;
      immhi_q <= '0;
    end else begin
      if (clr) begin
        tflag <= 1'b0;
        iflag <= 1'b0;
      end
      if (set_t) begin
        tflag <= 1'b1;
        ta3_q <= ta3;
        ta4_q <= ta4;
        tt3_q <= tt3;
        tt4_q <= tt4;
      end
      if (set_i) begin
        iflag   <= 1'b1;
        immhi_q <= immhi;
      end
    end
  end

  assign pending = tflag | iflag;
  assign imm     = iflag ? {immhi_q, immlo} : {{26{immlo[5]}}, immlo};
  assign ta      = tflag ? {ta4_q, ta3_q, ta2, ta1} : {12'd0, ta2, ta1};
  assign tt      = tflag ? {tt4_q, tt3_q, tt2, tt1} : {4'd0, tt2, tt1};
  assign ntgt    = tflag ? 3'd4 : 3'd2;

endmodule

// File: rtl/frag_issue_seq.sv
// Fetch-side fragment sequencer: opens/closes fragments and issues one packet per main word.
// Optional SEQ_PERF_CNT_EN adds perf_issued/perf_stall handshake and stall counters.
//   state | meaning
//   IDLE  | outside a fragment, only a fragment-start word is legal
//   FRAG  | inside a fragment, rem main words still expected
module frag_issue_seq
  import cgra_isa_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  frag_issue_seq_if.slave    bus,
  output logic               frag_start,
  output logic               frag_done,
  output logic               err
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [31:0]        perf_issued,
  output logic [31:0]        perf_stall
`endif
);

  state_t                state, state_nxt;
  logic [NALLOC_W-1:0]   rem, rem_nxt;
  logic                  accept, load, set_t, set_i, clr;
  logic                  start_nxt, done_nxt, err_nxt, pending;

  logic [2:0]            d_op;
  logic [3:0]            d_funct;
  logic [5:0]            d_immlo;
  logic [25:0]           d_immhi;
  logic [TA_W-1:0]       d_ta1, d_ta2, d_ta3, d_ta4;
  logic [1:0]            d_tt1, d_tt2, d_tt3, d_tt4;
  logic [NALLOC_W-1:0]   d_nalloc;
  logic                  d_endf;
  logic [31:0]           m_imm;
  logic [23:0]           m_ta;
  logic [7:0]            m_tt;
  logic [2:0]            m_ntgt;

  decoder u_dec (
    .instr (bus.instr), .op (d_op), .funct (d_funct), .immlo (d_immlo), .immhi (d_immhi),
    .ta1 (d_ta1), .ta2 (d_ta2), .ta3 (d_ta3), .ta4 (d_ta4),
    .tt1 (d_tt1), .tt2 (d_tt2), .tt3 (d_tt3), .tt4 (d_tt4),
    .nalloc (d_nalloc), .endf (d_endf)
  );

  prefix_merge u_merge (
    .clk (clk), .rst (rst), .set_t (set_t), .set_i (set_i), .clr (clr),
    .ta1 (d_ta1), .ta2 (d_ta2), .ta3 (d_ta3), .ta4 (d_ta4),
    .tt1 (d_tt1), .tt2 (d_tt2), .tt3 (d_tt3), .tt4 (d_tt4),
    .immhi (d_immhi), .immlo (d_immlo),
    .pending (pending), .imm (m_imm), .ta (m_ta), .tt (m_tt), .ntgt (m_ntgt)
  );

  // every word, prefixes included, waits for the single output slot
  assign bus.instr_ready = !bus.iss_valid | bus.iss_ready;
  assign accept          = bus.instr_valid & bus.instr_ready;

  always_comb begin
    state_nxt = state;
    rem_nxt   = rem;
    load      = 1'b0;
    set_t     = 1'b0;
    set_i     = 1'b0;
    clr       = 1'b0;
    start_nxt = 1'b0;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    if (accept) begin
      case (state)
        IDLE: begin
          if (d_op == OP_FRAG && !d_endf && d_nalloc != '0) begin
            state_nxt = FRAG;
            rem_nxt   = d_nalloc;
            start_nxt = 1'b1;
          end else begin
            err_nxt = 1'b1;
          end
        end
        FRAG: begin
          case (d_op)
            OP_ALU, OP_LD, OP_ST: begin
              load    = 1'b1;
              clr     = 1'b1;
              rem_nxt = rem - NALLOC_W'(1);
              if (rem == NALLOC_W'(1)) begin
                done_nxt  = 1'b1;
                state_nxt = IDLE;
              end
            end
            OP_TPFX: begin
              set_t   = 1'b1;
              err_nxt = pending;
            end
            OP_IPFX: begin
              set_i   = 1'b1;
              err_nxt = pending;
            end
            OP_FRAG: begin
              if (d_endf) begin
                done_nxt  = 1'b1;
                state_nxt = IDLE;
                clr       = 1'b1;
                rem_nxt   = '0;
                err_nxt   = (rem != '0) | pending;
              end else begin
                err_nxt = 1'b1;
              end
            end
            default: err_nxt = 1'b1;
          endcase
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      rem           <= '0;
      frag_start    <= 1'b0;
      frag_done     <= 1'b0;
      err           <= 1'b0;
      bus.iss_valid <= 1'b0;
      bus.iss_op    <= '0;
      bus.iss_funct <= '0;
      bus.iss_imm   <= '0;
      bus.iss_ta    <= '0;
      bus.iss_tt    <= '0;
      bus.iss_ntgt  <= '0;
    end else begin
      state      <= state_nxt;
      rem        <= rem_nxt;
      frag_start <= start_nxt;
      frag_done  <= done_nxt;
      err        <= err_nxt;
      if (load) begin
        bus.iss_valid <= 1'b1;
        bus.iss_op    <= d_op;
        bus.iss_funct <= d_funct;
        bus.iss_imm   <= m_imm;
        bus.iss_ta    <= m_ta;
        bus.iss_tt    <= m_tt;
        bus.iss_ntgt  <= m_ntgt;
      end else if (bus.iss_ready) begin
        bus.iss_valid <= 1'b0;
      end
    end
  end

`ifdef SEQ_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_issued <= '0;
      perf_stall  <= '0;
    end else begin
      if (bus.iss_valid & bus.iss_ready)  perf_issued <= perf_issued + 32'd1;
      if (bus.iss_valid & !bus.iss_ready) perf_stall  <= perf_stall + 32'd1;
    end
  end
`endif

endmodule
